// File: rtl/alu_pkg.sv
// Shared types for the ALU execute stage: control codes and FSM states.
package alu_pkg;

    // Control codes as produced by the upstream ALU control decoder.
    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_MUL = 4'b1000
    } alu_ctrl_e;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_e;

    // True for codes handled in a single registered cycle.
    function automatic logic is_single_cycle(input logic [3:0] code);
        return (code == ALU_AND) || (code == ALU_OR) || (code == ALU_ADD) ||
               (code == ALU_SUB) || (code == ALU_SLT);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational single-cycle datapath: AND/OR/ADD/SUB/SLT plus signed overflow.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ctrl,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             ovf_add;
    logic             ovf_sub;
    logic             lt;

    assign sum  = a + b;
    assign diff = a - b;

    // Overflow: operands' signs relate as the op requires, result sign differs from A.
    assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1]  != a[WIDTH-1]);
    assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]);

    // Signed less-than from the subtract: sign corrected by overflow.
    assign lt = diff[WIDTH-1] ^ ovf_sub;

    // Select the result for the decoded op; unknown codes yield zero.
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (ctrl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: begin
                result   = sum;
                overflow = ovf_add;
            end
            ALU_SUB: begin
                result   = diff;
                overflow = ovf_sub;
            end
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, lt};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage: registered single-cycle ops and an iterative shift-add multiplier.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             kill_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ALUCtrl_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             illegal_o,
    output logic             valid_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state;
    state_e           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] comb_result;
    logic             comb_overflow;
    logic             accept;
    logic             is_mul;
    logic             is_single;
    logic             mul_last;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .a        (src1_i),
        .b        (src2_i),
        .ctrl     (ALUCtrl_i),
        .result   (comb_result),
        .overflow (comb_overflow)
    );

    assign ready_o   = (state == IDLE);
    // A killed offer is never accepted.
    assign accept    = valid_i & ready_o & ~kill_i;
    assign is_mul    = (ALUCtrl_i == ALU_MUL);
    assign is_single = is_single_cycle(ALUCtrl_i);
    assign mul_last  = (cnt == CW'(WIDTH - 1));
    assign acc_nxt   = b_q[cnt] ? (acc + (a_q << cnt)) : acc;

    // Next-state logic: kill wins, MUL runs WIDTH busy cycles.
    always_comb begin
        state_nxt = state;
        if (kill_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:     if (accept && is_mul) state_nxt = MUL_BUSY;
                MUL_BUSY: if (mul_last)         state_nxt = IDLE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Multiplier operand latches, bit counter and accumulator.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            acc <= '0;
            cnt <= '0;
        end else if (accept && is_mul) begin
            a_q <= src1_i;
            b_q <= src2_i;
            acc <= '0;
            cnt <= '0;
        end else if (state == MUL_BUSY && !kill_i) begin
            acc <= acc_nxt;
            cnt <= cnt + CW'(1);
        end
    end

    // Output registers; valid_o is a one-cycle pulse, result holds otherwise.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            result_o   <= '0;
            zero_o     <= 1'b1;
            overflow_o <= 1'b0;
            illegal_o  <= 1'b0;
            valid_o    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (kill_i) begin
                valid_o <= 1'b0;
            end else if (accept && !is_mul) begin
                result_o   <= is_single ? comb_result : '0;
                zero_o     <= is_single ? (comb_result == '0) : 1'b1;
                overflow_o <= is_single & comb_overflow;
                illegal_o  <= ~is_single;
                valid_o    <= 1'b1;
            end else if (state == MUL_BUSY && mul_last) begin
                result_o   <= acc_nxt;
                zero_o     <= (acc_nxt == '0);
                overflow_o <= 1'b0;
                illegal_o  <= 1'b0;
                valid_o    <= 1'b1;
            end
        end
    end

endmodule
